// File: rtl/pal_pkg.sv
// Shared definitions for the palette CPU/video arbiter: FSM encoding, RAM geometry, latched request.
// Latency: none, this file holds definitions only.
// Backpressure: none, this file holds definitions only.
package pal_pkg;

  localparam int PAL_AW = 11;
  localparam int PAL_DW = 8;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WAIT    = 3'd1;
  localparam logic [2:0] ST_ACCESS  = 3'd2;
  localparam logic [2:0] ST_CAPTURE = 3'd3;
  localparam logic [2:0] ST_ACK     = 3'd4;

  // CPU request captured when the chip select is first seen
  typedef struct packed {
    logic              wr;     // 1 = write
    logic [PAL_AW-1:0] entry;  // palette entry, AB[12:2]
    logic              lo;     // 1 = LO byte bank
    logic [PAL_DW-1:0] dat;    // write data
  } cpu_req_t;

endpackage

// File: rtl/pal_slot_timer.sv
// Free-running pixel slot counter and the "CPU may use the RAM" qualifier.
// Latency: slot_ok is combinational from the counter, NCBLK and the wait count.
// Backpressure: none; the FSM samples slot_ok only while a request is waiting.
module pal_slot_timer #(
  parameter int SLOT_PERIOD = 4,
  parameter int STEAL_EN    = 1,
  parameter int MAX_WAIT    = 255
) (
  input  logic       v6m,
  input  logic       reset,
  input  logic       ncblk,
  input  logic [7:0] wait_cnt,
  output logic       slot_ok
);

  localparam int              CW    = (SLOT_PERIOD > 2) ? $clog2(SLOT_PERIOD) : 1;
  localparam logic [CW-1:0]   LAST  = CW'(SLOT_PERIOD - 1);
  localparam logic [7:0]      MAX_W = 8'(MAX_WAIT);
  localparam logic            STEAL = (STEAL_EN != 0);

  logic [CW-1:0] slot_cnt;

  // Count pixel clocks modulo SLOT_PERIOD, running through blanking as well
  always_ff @(posedge v6m) begin
    if (reset) begin
      slot_cnt <= '0;
    end else if (slot_cnt == LAST) begin
      slot_cnt <= '0;
    end else begin
      slot_cnt <= slot_cnt + CW'(1);
    end
  end

  // The FSM decides one cycle ahead of the access, so the steal term looks at the
  // last count: the ACCESS cycle itself then lands on slot counter == 0.
  assign slot_ok = ~ncblk | (STEAL & (slot_cnt == LAST)) | (wait_cnt == MAX_W);

endmodule

// File: rtl/pal_cpu_arbiter.sv
// Shares the HI/LO palette RAM between the video pixel path (default owner) and the 68000.
// Latency: request to NDTACK low is 3 cycles (write) / 4 cycles (read) with a free slot, MAX_WAIT+4 worst case.
// Backpressure: the CPU is held with NDTACK high until its access completes; video is never stalled, only flagged via PIX_HOLD.
module pal_cpu_arbiter
  import pal_pkg::*;
#(
  parameter int SLOT_PERIOD = 4,
  parameter int STEAL_EN    = 1,
  parameter int MAX_WAIT    = 255
) (
  input  logic        V6M,
  input  logic        RESET,
  input  logic        NCOLCS,
  input  logic        NREAD,
  input  logic [12:1] AB,
  input  logic [7:0]  CPU_DIN,
  output logic [7:0]  CPU_DOUT,
  output logic        NDTACK,
  input  logic        NCBLK,
  input  logic [9:0]  CD,
  output logic [10:0] RAM_ADDR,
  output logic [7:0]  RAM_DIN,
  output logic        RAM_WE_HI,
  output logic        RAM_WE_LO,
  input  logic [7:0]  RAM_DOUT_HI,
  input  logic [7:0]  RAM_DOUT_LO,
  output logic        VID_OWN,
  output logic        PIX_HOLD,
  output logic [15:0] STEAL_CNT
);

  localparam logic [7:0] MAX_W = 8'(MAX_WAIT);

  logic [2:0] state;
  cpu_req_t   req;
  logic [7:0] wait_cnt;
  logic       slot_ok;

  pal_slot_timer #(
    .SLOT_PERIOD (SLOT_PERIOD),
    .STEAL_EN    (STEAL_EN),
    .MAX_WAIT    (MAX_WAIT)
  ) u_slot_timer (
    .v6m      (V6M),
    .reset    (RESET),
    .ncblk    (NCBLK),
    .wait_cnt (wait_cnt),
    .slot_ok  (slot_ok)
  );

  // Request sequencing: latch on chip select, wait for a slot, access, optional capture, ack
  always_ff @(posedge V6M) begin
    if (RESET) begin
      state <= ST_IDLE;
      req   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!NCOLCS) begin
            req   <= '{wr: NREAD, entry: AB[12:2], lo: AB[1], dat: CPU_DIN};
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // A CPU that gives up must not get a late write, so abort wins over a slot
          if (NCOLCS) begin
            state <= ST_IDLE;
          end else if (slot_ok) begin
            state <= ST_ACCESS;
          end
        end
        ST_ACCESS: state <= req.wr ? ST_ACK : ST_CAPTURE;
        ST_CAPTURE: state <= ST_ACK;
        ST_ACK: begin
          if (NCOLCS) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Cycles spent waiting for a slot; saturates at the forced-steal threshold
  always_ff @(posedge V6M) begin
    if (RESET) begin
      wait_cnt <= '0;
    end else if (state == ST_IDLE && !NCOLCS) begin
      wait_cnt <= '0;
    end else if (state == ST_WAIT && wait_cnt != MAX_W) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

  // Read data arrives one cycle after the address, so grab it in CAPTURE and hold it
  always_ff @(posedge V6M) begin
    if (RESET) begin
      CPU_DOUT <= '0;
    end else if (state == ST_CAPTURE) begin
      CPU_DOUT <= req.lo ? RAM_DOUT_LO : RAM_DOUT_HI;
    end
  end

  // Count accesses that displaced a visible pixel
  always_ff @(posedge V6M) begin
    if (RESET) begin
      STEAL_CNT <= '0;
    end else if (state == ST_ACCESS && NCBLK && STEAL_CNT != 16'hFFFF) begin
      STEAL_CNT <= STEAL_CNT + 16'd1;
    end
  end

  // RAM port mux: video address except during the single CPU access cycle
  always_comb begin
    VID_OWN   = 1'b1;
    RAM_ADDR  = {1'b0, CD};
    RAM_DIN   = req.dat;
    RAM_WE_HI = 1'b0;
    RAM_WE_LO = 1'b0;
    PIX_HOLD  = 1'b0;
    if (state == ST_ACCESS) begin
      VID_OWN   = 1'b0;
      RAM_ADDR  = req.entry;
      RAM_WE_LO = req.wr & req.lo;
      RAM_WE_HI = req.wr & ~req.lo;
      PIX_HOLD  = NCBLK;
    end
  end

  assign NDTACK = (state != ST_ACK);

endmodule

// File: tb/tb_pal_cpu_arbiter.sv
// Bench for the palette arbiter: default instance plus a no-steal, short-timeout instance.
// Latency: n/a.
// Backpressure: n/a.
module tb_pal_cpu_arbiter;

  typedef struct packed {
    logic        sel;
    logic [10:0] addr;
    logic        lo;
    logic [7:0]  dat;
  } wr_exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        nread;
  logic [12:1] ab;
  logic [7:0]  din;
  logic [9:0]  cd;
  logic        ncolcs0, ncblk0, ncolcs1, ncblk1;

  logic [7:0]  dout0, dout1, ram_din0, ram_din1;
  logic        ndtack0, ndtack1;
  logic [10:0] ram_addr0, ram_addr1;
  logic        we_hi0, we_lo0, we_hi1, we_lo1;
  logic        vid_own0, vid_own1, pix_hold0, pix_hold1;
  logic [15:0] steal_cnt0, steal_cnt1;
  logic [7:0]  ram_dout_hi0, ram_dout_lo0;
  logic [7:0]  ram_dout_hi1 = 8'hB7;
  logic [7:0]  ram_dout_lo1 = 8'h4E;

  logic [7:0]  mem_hi [0:2047];
  logic [7:0]  mem_lo [0:2047];
  logic [7:0]  exp_hi [0:2047];
  logic [7:0]  exp_lo [0:2047];

  wr_exp_t     wq[$];
  logic [7:0]  rq[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          we_cnt0 = 0, we_cnt1 = 0, hold_cnt0 = 0, hold_cnt1 = 0;
  int          slot_m = 0;
  int          lat, base;

  always #5 clk = ~clk;

  pal_cpu_arbiter dut0 (
    .V6M(clk), .RESET(reset), .NCOLCS(ncolcs0), .NREAD(nread), .AB(ab), .CPU_DIN(din),
    .CPU_DOUT(dout0), .NDTACK(ndtack0), .NCBLK(ncblk0), .CD(cd), .RAM_ADDR(ram_addr0),
    .RAM_DIN(ram_din0), .RAM_WE_HI(we_hi0), .RAM_WE_LO(we_lo0), .RAM_DOUT_HI(ram_dout_hi0),
    .RAM_DOUT_LO(ram_dout_lo0), .VID_OWN(vid_own0), .PIX_HOLD(pix_hold0), .STEAL_CNT(steal_cnt0)
  );

  pal_cpu_arbiter #(.SLOT_PERIOD(4), .STEAL_EN(0), .MAX_WAIT(10)) dut1 (
    .V6M(clk), .RESET(reset), .NCOLCS(ncolcs1), .NREAD(nread), .AB(ab), .CPU_DIN(din),
    .CPU_DOUT(dout1), .NDTACK(ndtack1), .NCBLK(ncblk1), .CD(cd), .RAM_ADDR(ram_addr1),
    .RAM_DIN(ram_din1), .RAM_WE_HI(we_hi1), .RAM_WE_LO(we_lo1), .RAM_DOUT_HI(ram_dout_hi1),
    .RAM_DOUT_LO(ram_dout_lo1), .VID_OWN(vid_own1), .PIX_HOLD(pix_hold1), .STEAL_CNT(steal_cnt1)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic ndt(input int s);
    return (s == 0) ? ndtack0 : ndtack1;
  endfunction

  function automatic logic [7:0] dout(input int s);
    return (s == 0) ? dout0 : dout1;
  endfunction

  task automatic pop_wr(input logic s, input logic [10:0] a, input logic hi, input logic lo,
                        input logic [7:0] d, input logic own);
    wr_exp_t e;
    if (wq.size() == 0) begin
      chk("wr_unexpected", wq.size(), 1);
    end else begin
      e = wq.pop_front();
      chk("wr_dut", s, e.sel);
      chk("wr_addr", a, e.addr);
      chk("wr_bank_lo", lo, e.lo);
      chk("wr_one_bank", hi ^ lo, 1);
      chk("wr_data", d, e.dat);
      chk("wr_vid_own", own, 0);
    end
  endtask

  // Palette RAM for dut0: synchronous write, 1-cycle registered read
  always @(posedge clk) begin
    if (we_hi0) mem_hi[ram_addr0] <= ram_din0;
    if (we_lo0) mem_lo[ram_addr0] <= ram_din0;
    ram_dout_hi0 <= mem_hi[ram_addr0];
    ram_dout_lo0 <= mem_lo[ram_addr0];
  end

  // Reference slot position for dut0 (period 4)
  always @(posedge clk) slot_m <= reset ? 0 : (slot_m + 1) % 4;

  // Output monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (vid_own0) begin
      chk("vid_addr0", ram_addr0, {1'b0, cd});
      chk("hold_own0", pix_hold0, 0);
    end else begin
      chk("hold_blank0", pix_hold0, ncblk0);
      if (ncblk0) chk("steal_slot0", slot_m, 0);
    end
    if (vid_own1) chk("vid_addr1", ram_addr1, {1'b0, cd});
    if (we_hi0 | we_lo0) begin
      we_cnt0++;
      pop_wr(1'b0, ram_addr0, we_hi0, we_lo0, ram_din0, vid_own0);
    end
    if (we_hi1 | we_lo1) begin
      we_cnt1++;
      pop_wr(1'b1, ram_addr1, we_hi1, we_lo1, ram_din1, vid_own1);
    end
    if (pix_hold0) hold_cnt0++;
    if (pix_hold1) hold_cnt1++;
  end

  // One CPU cycle on dut s; returns cycles from the request cycle to NDTACK low
  task automatic cpu_xfer(input int s, input logic wr, input logic [12:1] a, input logic [7:0] d,
                          input logic blank, input int budget, output int l);
    wr_exp_t e;
    @(posedge clk); #1;
    nread = wr; ab = a; din = d;
    if (wr) begin
      e.sel = (s != 0); e.addr = a[12:2]; e.lo = a[1]; e.dat = d;
      wq.push_back(e);
      if (s == 0) begin
        if (a[1]) exp_lo[a[12:2]] = d;
        else      exp_hi[a[12:2]] = d;
      end
    end else if (s == 0) begin
      rq.push_back(a[1] ? exp_lo[a[12:2]] : exp_hi[a[12:2]]);
    end else begin
      rq.push_back(a[1] ? 8'h4E : 8'hB7);
    end
    if (s == 0) begin ncblk0 = ~blank; ncolcs0 = 1'b0; end
    else        begin ncblk1 = ~blank; ncolcs1 = 1'b0; end
    l = 0;
    do begin
      @(posedge clk); #1;
      l++;
    end while (ndt(s) == 1'b1 && l < budget);
    chk("ack_seen", ndt(s), 0);
    if (!wr) chk("rd_data", dout(s), rq.pop_front());
  endtask

  task automatic cpu_release(input int s);
    if (s == 0) ncolcs0 = 1'b1; else ncolcs1 = 1'b1;
    @(posedge clk); #1;
    chk("ack_release", ndt(s), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // Video colour index changes every pixel
  initial begin
    cd = 10'h155;
    forever begin
      @(posedge clk); #1;
      cd = 10'($urandom);
    end
  end

  initial begin
    for (int i = 0; i < 2048; i++) begin
      mem_hi[i] = 8'(i * 7 + 3);
      mem_lo[i] = 8'(i * 13 + 1) ^ 8'h5A;
      exp_hi[i] = mem_hi[i];
      exp_lo[i] = mem_lo[i];
    end
    mem_hi[11'h020] = 8'hC3;
    exp_hi[11'h020] = 8'hC3;
    reset = 1'b1; ncolcs0 = 1'b1; ncolcs1 = 1'b1; ncblk0 = 1'b0; ncblk1 = 1'b0;
    nread = 1'b1; ab = '0; din = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ndtack", ndtack0, 1);
    chk("rst_dout", dout0, 0);
    chk("rst_we", {we_hi0, we_lo0}, 0);
    chk("rst_vid_own", vid_own0, 1);
    chk("rst_pix_hold", pix_hold0, 0);
    chk("rst_steal", steal_cnt0, 0);
    chk("rst_ndtack1", ndtack1, 1);
    reset = 1'b0;

    // Write in blanking: entry 0x021, LO byte
    cpu_xfer(0, 1'b1, 12'h043, 8'h5A, 1'b1, 20, lat);
    chk("t1_latency", lat, 3);
    chk("t1_we_cnt", we_cnt0, 1);
    cpu_release(0);
    chk("t1_steal", steal_cnt0, 0);

    // Read it back in blanking
    cpu_xfer(0, 1'b0, 12'h043, 8'h00, 1'b1, 20, lat);
    chk("t1b_latency", lat, 4);
    cpu_release(0);
    chk("t1b_we_cnt", we_cnt0, 1);

    // Read entry 0x020 HI during active display: steals one pixel
    cpu_xfer(0, 1'b0, 12'h040, 8'h00, 1'b0, 20, lat);
    chk("t2_latency_rng", (lat >= 4 && lat <= 7), 1);
    chk("t2_hold_cnt", hold_cnt0, 1);
    chk("t2_steal", steal_cnt0, 1);
    cpu_release(0);

    // Write during active display, top entry, HI byte
    cpu_xfer(0, 1'b1, 12'hFFE, 8'hA5, 1'b0, 20, lat);
    chk("t2b_latency_rng", (lat >= 3 && lat <= 6), 1);
    chk("t2b_steal", steal_cnt0, 2);
    cpu_release(0);

    // Chip select held low after ack: only one access until it toggles
    base = we_cnt0;
    cpu_xfer(0, 1'b1, 12'h100, 8'h11, 1'b1, 20, lat);
    repeat (8) @(posedge clk);
    #1;
    chk("t6_ack_held", ndtack0, 0);
    chk("t6_one_write", we_cnt0 - base, 1);
    cpu_release(0);
    cpu_xfer(0, 1'b0, 12'h100, 8'h00, 1'b1, 20, lat);
    chk("t6_second_lat", lat, 4);
    cpu_release(0);
    chk("t6_no_extra_wr", we_cnt0 - base, 1);

    // Abort while waiting on the no-steal instance
    @(posedge clk); #1;
    ncblk1 = 1'b1; nread = 1'b1; ab = 12'h010; din = 8'hFF; ncolcs1 = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    chk("t4_no_ack", ndtack1, 1);
    ncolcs1 = 1'b1;
    repeat (12) begin @(posedge clk); #1; end
    chk("t4_no_write", we_cnt1, 0);
    chk("t4_no_ack_after", ndtack1, 1);
    cpu_xfer(1, 1'b1, 12'h011, 8'h66, 1'b1, 20, lat);
    chk("t4_idle_latency", lat, 3);
    cpu_release(1);

    // Forced steals after MAX_WAIT on the no-steal instance
    cpu_xfer(1, 1'b1, 12'h022, 8'h77, 1'b0, 40, lat);
    chk("t3_wr_latency", lat, 13);
    chk("t3_hold_cnt", hold_cnt1, 1);
    chk("t3_steal", steal_cnt1, 1);
    cpu_release(1);
    cpu_xfer(1, 1'b0, 12'h022, 8'h00, 1'b0, 40, lat);
    chk("t3_rd_latency", lat, 14);
    chk("t3_steal2", steal_cnt1, 2);
    cpu_release(1);
    ncblk1 = 1'b0;

    // Reset arriving in the ACCESS cycle of a write
    base = we_cnt0;
    @(posedge clk); #1;
    ncblk0 = 1'b0; nread = 1'b1; ab = 12'h200; din = 8'h99;
    wq.push_back('{sel: 1'b0, addr: 11'h100, lo: 1'b0, dat: 8'h99});
    exp_hi[11'h100] = 8'h99;
    ncolcs0 = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    chk("t5_in_access", vid_own0, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("t5_ndtack", ndtack0, 1);
    chk("t5_vid_own", vid_own0, 1);
    chk("t5_we", {we_hi0, we_lo0}, 0);
    chk("t5_pix_hold", pix_hold0, 0);
    chk("t5_steal", steal_cnt0, 0);
    chk("t5_dout", dout0, 0);
    chk("t5_addr_cd", ram_addr0, {1'b0, cd});
    ncolcs0 = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    chk("t5_we_cnt", we_cnt0 - base, 1);
    chk("t5_idle_ack", ndtack0, 1);
    cpu_xfer(0, 1'b0, 12'h200, 8'h00, 1'b1, 20, lat);
    chk("t5_retry_lat", lat, 4);
    cpu_release(0);
    chk("wq_drained", wq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
